hit_packer: RTL and testbench



---
 rtl/hit_packer_pkg.sv | 22 ++
 rtl/hit_out_reg.sv | 51 +++++
 rtl/hit_packer.sv | 159 +++++++++++++++
 tb/tb_hit_packer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hit_packer_pkg.sv
// Shared raster definitions for the R16->R18 hit packer: word sizes, FSM states and sample payload.
package hit_packer_pkg;

  localparam int unsigned SIGFIG = 24;
  localparam int unsigned RADIX  = 10;
  localparam int unsigned AXIS   = 3;
  localparam int unsigned COLORS = 3;
  localparam int unsigned LANES  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FLUSH = 2'd2
  } pk_state_t;

  typedef struct packed {
    logic [AXIS-1:0][SIGFIG-1:0]   pos;
    logic [COLORS-1:0][SIGFIG-1:0] color;
    logic                          last;
  } hit_sample_t;

endpackage

// File: rtl/hit_out_reg.sv
// One-deep valid/ready output register for a hit bundle; unused lanes are zeroed on load.
module hit_out_reg #(
  parameter int unsigned SIGFIG = 24,
  parameter int unsigned AXIS   = 3,
  parameter int unsigned COLORS = 3,
  parameter int unsigned LANES  = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        load,
  input  logic [LANES-1:0][AXIS-1:0][SIGFIG-1:0]      lanes_in,
  input  logic [COLORS-1:0][SIGFIG-1:0]               color_in,
  input  logic [CNT_W-1:0]                            cnt_in,
  input  logic                                        out_ready,
  output logic                                        can_load_c,
  output logic signed [LANES-1:0][AXIS-1:0][SIGFIG-1:0] hit,
  output logic [LANES-1:0][COLORS-1:0][SIGFIG-1:0]    color,
  output logic [LANES-1:0]                            valid
);

  logic full_q;

  assign can_load_c = !full_q || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      hit    <= '0;
      color  <= '0;
      valid  <= '0;
    end else if (load) begin
      full_q <= 1'b1;
      for (int i = 0; i < LANES; i++) begin
        if (CNT_W'(i) < cnt_in) begin
          hit[i]   <= lanes_in[i];
          valid[i] <= 1'b1;
        end else begin
          hit[i]   <= '0;
          valid[i] <= 1'b0;
        end
        color[i] <= color_in;
      end
    end else if (out_ready) begin
      // Payload is left in place; only the mask drops when the consumer takes it.
      full_q <= 1'b0;
      valid  <= '0;
    end
  end

endmodule

// File: rtl/hit_packer.sv
// Packs single-sample hits into 4-lane single-color bundles for the z-buffer stage.
module hit_packer #(
  parameter int unsigned SIGFIG        = hit_packer_pkg::SIGFIG,
  parameter int unsigned AXIS          = hit_packer_pkg::AXIS,
  parameter int unsigned COLORS        = hit_packer_pkg::COLORS,
  parameter int unsigned LANES         = hit_packer_pkg::LANES,
  parameter int unsigned FLUSH_TIMEOUT = 8
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic signed [AXIS-1:0][SIGFIG-1:0]            hit_R16S,
  input  logic [COLORS-1:0][SIGFIG-1:0]                 color_R16U,
  input  logic                                          hit_valid_R16H,
  input  logic                                          hit_last_R16H,
  output logic                                          halt_R16H,
  output logic signed [LANES-1:0][AXIS-1:0][SIGFIG-1:0] hit_R18S,
  output logic [LANES-1:0][COLORS-1:0][SIGFIG-1:0]      color_R18U,
  output logic [LANES-1:0]                              hit_valid_R18H,
  input  logic                                          out_ready_R18H
);

  import hit_packer_pkg::*;

  localparam int unsigned CNT_W  = $clog2(LANES + 1);
  localparam int unsigned IDLE_W = 8;

  typedef logic [AXIS-1:0][SIGFIG-1:0]   pos_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0] col_t;

  pk_state_t               state_q, state_d;
  pos_t      [LANES-1:0]   lane_q, lane_d;
  col_t                    acc_color_q, acc_color_d;
  logic      [CNT_W-1:0]   cnt_q, cnt_d;
  logic      [IDLE_W-1:0]  idle_q, idle_d;
  pos_t                    pend_pos_q, pend_pos_d;
  col_t                    pend_color_q, pend_color_d;
  logic                    pend_vld_q, pend_vld_d;
  logic                    pend_last_q, pend_last_d;
  logic                    halt_q;
  logic                    accept_c, same_color_c, can_load_c, load_c;

  assign accept_c     = hit_valid_R16H && !halt_q;
  assign same_color_c = (color_R16U == acc_color_q);
  assign halt_R16H    = halt_q;

  // Next-state and accumulator update.
  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    acc_color_d  = acc_color_q;
    cnt_d        = cnt_q;
    idle_d       = idle_q;
    pend_pos_d   = pend_pos_q;
    pend_color_d = pend_color_q;
    pend_vld_d   = pend_vld_q;
    pend_last_d  = pend_last_q;
    load_c       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          lane_d[0]   = hit_R16S;
          cnt_d       = CNT_W'(1);
          acc_color_d = color_R16U;
          idle_d      = '0;
          state_d     = hit_last_R16H ? ST_FLUSH : ST_FILL;
        end
      end
      ST_FILL: begin
        if (accept_c && same_color_c) begin
          for (int i = 0; i < LANES; i++) begin
            if (CNT_W'(i) == cnt_q) lane_d[i] = hit_R16S;
          end
          cnt_d  = cnt_q + CNT_W'(1);
          idle_d = '0;
          if (cnt_d == CNT_W'(LANES) || hit_last_R16H) state_d = ST_FLUSH;
        end else if (accept_c) begin
          // Color change: park the sample and seal what we have.
          pend_vld_d   = 1'b1;
          pend_pos_d   = hit_R16S;
          pend_color_d = color_R16U;
          pend_last_d  = hit_last_R16H;
          idle_d       = '0;
          state_d      = ST_FLUSH;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
          if (idle_d == IDLE_W'(FLUSH_TIMEOUT)) begin
            idle_d  = '0;
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        idle_d = '0;
        if (can_load_c) begin
          load_c = 1'b1;
          if (pend_vld_q) begin
            lane_d[0]   = pend_pos_q;
            cnt_d       = CNT_W'(1);
            acc_color_d = pend_color_q;
            pend_vld_d  = 1'b0;
            pend_last_d = 1'b0;
            state_d     = pend_last_q ? ST_FLUSH : ST_FILL;
          end else begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      lane_q       <= '0;
      acc_color_q  <= '0;
      cnt_q        <= '0;
      idle_q       <= '0;
      pend_pos_q   <= '0;
      pend_color_q <= '0;
      pend_vld_q   <= 1'b0;
      pend_last_q  <= 1'b0;
      halt_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      acc_color_q  <= acc_color_d;
      cnt_q        <= cnt_d;
      idle_q       <= idle_d;
      pend_pos_q   <= pend_pos_d;
      pend_color_q <= pend_color_d;
      pend_vld_q   <= pend_vld_d;
      pend_last_q  <= pend_last_d;
      halt_q       <= (state_d == ST_FLUSH);
    end
  end

  hit_out_reg #(
    .SIGFIG (SIGFIG),
    .AXIS   (AXIS),
    .COLORS (COLORS),
    .LANES  (LANES),
    .CNT_W  (CNT_W)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_c),
    .lanes_in   (lane_q),
    .color_in   (acc_color_q),
    .cnt_in     (cnt_q),
    .out_ready  (out_ready_R18H),
    .can_load_c (can_load_c),
    .hit        (hit_R18S),
    .color      (color_R18U),
    .valid      (hit_valid_R18H)
  );

endmodule

// File: tb/tb_hit_packer.sv
// Directed bench for hit_packer: sample-grouping model plus hand-computed timing and mask expectations.
module tb_hit_packer;
  import hit_packer_pkg::*;

  localparam int unsigned N_TO = 8;

  typedef logic [COLORS-1:0][SIGFIG-1:0] col_t;

  logic                                          clk;
  logic                                          rst_n;
  logic signed [AXIS-1:0][SIGFIG-1:0]            hit_i;
  col_t                                          color_i;
  logic                                          hv, hl, halt, ready;
  logic signed [LANES-1:0][AXIS-1:0][SIGFIG-1:0] hit_o;
  logic [LANES-1:0][COLORS-1:0][SIGFIG-1:0]      color_o;
  logic [LANES-1:0]                              valid_o;

  hit_packer #(.FLUSH_TIMEOUT(N_TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hit_R16S       (hit_i),
    .color_R16U     (color_i),
    .hit_valid_R16H (hv),
    .hit_last_R16H  (hl),
    .halt_R16H      (halt),
    .hit_R18S       (hit_o),
    .color_R18U     (color_o),
    .hit_valid_R18H (valid_o),
    .out_ready_R18H (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Model: accepted samples are grouped into bundles by the packing rules.
  hit_sample_t open_q[$];
  hit_sample_t exp_samp[$];
  int          exp_cnt[$];
  logic [3:0]  masks_seen[$];
  int          idle_m = 0;
  int          halt_cnt = 0;
  int          accepted_total = 0;
  int          delivered_total = 0;
  int          kseq = 0;

  logic                                          prev_hold = 1'b0;
  logic signed [LANES-1:0][AXIS-1:0][SIGFIG-1:0] prev_hit;
  logic [LANES-1:0][COLORS-1:0][SIGFIG-1:0]      prev_color;
  logic [LANES-1:0]                              prev_valid;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic col_t mkcol(input logic [23:0] r, input logic [23:0] g, input logic [23:0] b);
    col_t c;
    c[0] = r; c[1] = g; c[2] = b;
    return c;
  endfunction

  function automatic void seal();
    if (open_q.size() > 0) begin
      exp_cnt.push_back(open_q.size());
      foreach (open_q[i]) exp_samp.push_back(open_q[i]);
      open_q.delete();
    end
  endfunction

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    hit_sample_t s;
    col_t        ecol;
    int          n;
    logic [3:0]  emask;
    if (!rst_n) begin
      open_q.delete();
      exp_cnt.delete();
      exp_samp.delete();
      idle_m    = 0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold)
        chk("held_stable", 128'({hit_o == prev_hit, color_o == prev_color, valid_o == prev_valid}), 128'(3'b111));
      chk("mask_contig", 128'(valid_o inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111}), 128'(1'b1));
      if (halt) halt_cnt++;
      if (valid_o != '0 && ready) begin
        masks_seen.push_back(valid_o);
        delivered_total += $countones(valid_o);
        if (exp_cnt.size() == 0) begin
          chk("unexpected_bundle", 128'(valid_o), 128'(0));
        end else begin
          n     = exp_cnt.pop_front();
          emask = 4'((1 << n) - 1);
          chk("bundle_mask", 128'(valid_o), 128'(emask));
          ecol = '0;
          for (int l = 0; l < LANES; l++) begin
            if (l < n && exp_samp.size() > 0) begin
              s = exp_samp.pop_front();
              if (l == 0) ecol = s.color;
              chk("lane_pos", 128'(hit_o[l]), 128'(s.pos));
            end else begin
              chk("lane_zero", 128'(hit_o[l]), 128'(0));
            end
            chk("lane_color", 128'(color_o[l]), 128'(ecol));
          end
        end
      end
      prev_hold  = (valid_o != '0) && !ready;
      prev_hit   = hit_o;
      prev_color = color_o;
      prev_valid = valid_o;
      if (hv && !halt) begin
        s.pos   = hit_i;
        s.color = color_i;
        s.last  = hl;
        if (open_q.size() > 0 && s.color != open_q[0].color) seal();
        open_q.push_back(s);
        idle_m = 0;
        accepted_total++;
        if (open_q.size() == LANES || hl) seal();
      end else if (open_q.size() > 0) begin
        idle_m++;
        if (idle_m >= N_TO) begin
          seal();
          idle_m = 0;
        end
      end
    end
  end

  task automatic send(input col_t c, input logic last);
    logic acc;
    int   n;
    kseq++;
    hit_i[0] = 24'(kseq);
    hit_i[1] = 24'(kseq) + 24'h001000;
    hit_i[2] = 24'hF00000 | 24'(kseq);
    color_i  = c;
    hv       = 1'b1;
    hl       = last;
    n        = 0;
    acc      = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = !halt;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", 128'(0), 128'(1));
    hv = 1'b0;
    hl = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    col_t col_a, col_b, col_c;
    int   early;
    col_a = mkcol(24'h000100, 24'h000200, 24'h000300);
    col_b = mkcol(24'h000AAA, 24'h000BBB, 24'h000CCC);
    col_c = mkcol(24'h123456, 24'h654321, 24'h0F0F0F);
    rst_n   = 1'b0;
    hv      = 1'b0;
    hl      = 1'b0;
    hit_i   = '0;
    color_i = '0;
    ready   = 1'b1;
    #2;
    chk("reset_mask", 128'(valid_o), 128'(0));
    chk("reset_halt", 128'(halt), 128'(0));
    chk("reset_data", 128'({|hit_o, |color_o}), 128'(0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Four same-color samples back to back.
    for (int i = 0; i < 4; i++) send(col_a, 1'b0);
    @(negedge clk);
    chk("t1_flush_halt", 128'(halt), 128'(1));
    chk("t1_not_yet", 128'(valid_o), 128'(0));
    @(posedge clk); #1;
    chk("t1_latency_mask", 128'(valid_o), 128'(4'b1111));
    chk("t1_halt_drop", 128'(halt), 128'(0));
    idle(3);
    chk("t1_halt_cycles", 128'(halt_cnt), 128'(1));

    // Short triangle ending on its second sample.
    send(col_b, 1'b0);
    send(col_b, 1'b1);
    idle(4);
    chk("t2_mask", 128'(masks_seen[$]), 128'(4'b0011));

    // Color change after three samples; the odd one out times out alone.
    for (int i = 0; i < 3; i++) send(col_a, 1'b0);
    send(col_b, 1'b0);
    idle(14);
    chk("t3_mask_a", 128'(masks_seen[$-1]), 128'(4'b0111));
    chk("t3_mask_b", 128'(masks_seen[$]), 128'(4'b0001));

    // Lone sample sealed by the idle timeout, not before.
    send(col_c, 1'b0);
    early = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (valid_o != '0) early++;
    end
    @(negedge clk);
    chk("t4_no_early", 128'(early), 128'(0));
    chk("t4_mask", 128'(valid_o), 128'(4'b0001));
    @(posedge clk); #1;
    idle(2);

    // Downstream stall while eight samples are offered.
    fork
      begin
        ready = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        chk("t5_halt_held", 128'(halt), 128'(1));
        chk("t5_first_held", 128'(valid_o), 128'(4'b1111));
        @(posedge clk); #1;
        ready = 1'b1;
      end
      begin
        for (int i = 0; i < 8; i++) send(col_a, 1'b0);
      end
    join
    idle(6);
    chk("t5_mask_1", 128'(masks_seen[$-1]), 128'(4'b1111));
    chk("t5_mask_2", 128'(masks_seen[$]), 128'(4'b1111));

    // Reset with a partial bundle in flight.
    send(col_b, 1'b0);
    send(col_b, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_reset_mask", 128'(valid_o), 128'(0));
    chk("t6_reset_halt", 128'(halt), 128'(0));
    chk("t6_reset_data", 128'({|hit_o, |color_o}), 128'(0));
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send(col_c, 1'b0);
    idle(4);
    chk("t6_mask", 128'(masks_seen[$]), 128'(4'b1111));

    chk("drained_bundles", 128'(exp_cnt.size()), 128'(0));
    chk("drained_open", 128'(open_q.size()), 128'(0));
    chk("accepted_total", 128'(accepted_total), 128'(25));
    chk("delivered_total", 128'(delivered_total), 128'(23));
    chk("bundle_count", 128'(masks_seen.size()), 128'(8));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
